// File: rtl/up_pkg.sv
// up_pkg: shared definitions for the up interrupt controller.
//   N_IRQ_DEF - default number of peripheral request lines
//   VEC_W_DEF - default vector width, clog2(N_IRQ_DEF)
//   state_t   - controller state: idle, requesting, in service
package up_pkg;

  localparam int unsigned N_IRQ_DEF = 8;
  localparam int unsigned VEC_W_DEF = $clog2(N_IRQ_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

endpackage

// File: rtl/up_int_prio.sv
// up_int_prio: combinational lowest-index-wins priority encoder.
//   req   - request vector (N_IRQ bits)
//   idx   - index of the lowest set bit (0 when none set)
//   valid - at least one bit of req is set
module up_int_prio
  import up_pkg::*;
#(
  parameter int unsigned N_IRQ = N_IRQ_DEF,
  parameter int unsigned VEC_W = VEC_W_DEF
) (
  input  logic [N_IRQ-1:0] req,
  input  logic             valid_unused_guard,
  output logic [VEC_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = VEC_W'(i);
        valid = 1'b1;
      end else begin
        idx   = idx;
        valid = valid | (valid_unused_guard & 1'b0);
      end
    end
  end

endmodule

// File: rtl/up_int_ctrl.sv
// up_int_ctrl: interrupt controller in front of the up core's int input.
// Rising edges on irq set pending bits; pending bits not masked are offered
// to the core one at a time, lowest index first, through an ack/vector and
// end-of-interrupt handshake.
//   clk, rst    - clock and synchronous active-high reset
//   irq         - peripheral request lines, rising edge = request
//   mask_we     - mask register write strobe
//   mask_wdata  - new mask value, bit=1 disables that line
//   intr        - registered interrupt request to the core
//   int_ack     - one-cycle acknowledge from the core
//   int_vec     - registered index of the acknowledged line
//   int_eoi     - one-cycle end-of-interrupt from the core
//   pending     - pending register for status reads
//   in_service  - an acknowledged interrupt is being serviced
module up_int_ctrl
  import up_pkg::*;
#(
  parameter int unsigned N_IRQ = N_IRQ_DEF,
  parameter int unsigned VEC_W = VEC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic             intr,
  input  logic             int_ack,
  output logic [VEC_W-1:0] int_vec,
  input  logic             int_eoi,
  output logic [N_IRQ-1:0] pending,
  output logic             in_service
);

  logic [N_IRQ-1:0] irq_q_r;
  logic [N_IRQ-1:0] mask_r;
  logic [N_IRQ-1:0] edge_s;
  logic [N_IRQ-1:0] eligible_s;
  logic [N_IRQ-1:0] clr_s;
  logic [VEC_W-1:0] win_idx_s;
  logic             win_valid_s;
  logic             take_s;
  state_t           state_r;
  state_t           state_next_s;

  assign edge_s     = irq & ~irq_q_r;
  assign eligible_s = pending & ~mask_r;

  up_int_prio #(
    .N_IRQ (N_IRQ),
    .VEC_W (VEC_W)
  ) u_prio (
    .req                (eligible_s),
    .valid_unused_guard (1'b0),
    .idx                (win_idx_s),
    .valid              (win_valid_s)
  );

  // Next-state logic; take_s marks the cycle an acknowledge is accepted.
  always_comb begin
    state_next_s = state_r;
    take_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_valid_s && !in_service) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Masking away every candidate withdraws the request.
        if (!win_valid_s) begin
          state_next_s = ST_IDLE;
        end else if (int_ack) begin
          state_next_s = ST_SERV;
          take_s       = 1'b1;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_SERV: begin
        if (int_eoi) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SERV;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // One-hot clear of the pending bit that is being acknowledged.
  always_comb begin
    clr_s = '0;
    if (take_s) begin
      clr_s[win_idx_s] = 1'b1;
    end else begin
      clr_s = '0;
    end
  end

  // Edge history, pending, mask, state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q_r    <= '0;
      mask_r     <= '1;
      pending    <= '0;
      state_r    <= ST_IDLE;
      intr       <= 1'b0;
      int_vec    <= '0;
      in_service <= 1'b0;
    end else begin
      irq_q_r    <= irq;
      // A new edge on the bit being acknowledged keeps it pending.
      pending    <= (pending & ~clr_s) | edge_s;
      if (mask_we) begin
        mask_r <= mask_wdata;
      end
      state_r    <= state_next_s;
      intr       <= (state_next_s == ST_REQ);
      in_service <= (state_next_s == ST_SERV);
      if (take_s) begin
        int_vec <= win_idx_s;
      end
    end
  end

endmodule

// File: tb/tb_up_int_ctrl.sv
module tb_up_int_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] irq = '0;
  logic         mask_we = 1'b0;
  logic [N-1:0] mask_wdata = '0;
  logic         intr;
  logic         int_ack = 1'b0;
  logic [2:0]   int_vec;
  logic         int_eoi = 1'b0;
  logic [N-1:0] pending;
  logic         in_service;

  int n_tests = 0;
  int n_fail  = 0;

  up_int_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .intr       (intr),
    .int_ack    (int_ack),
    .int_vec    (int_vec),
    .int_eoi    (int_eoi),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks, in plain terms: whether an interrupt is being offered, whether
  // one is being serviced, which vector was last taken and the pending set.
  bit           m_offer;
  bit           m_serv;
  logic [2:0]   m_vec;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_mask;
  logic [N-1:0] m_prev;

  always @(posedge clk) begin
    int win;
    logic [N-1:0] np;
    if (rst) begin
      m_offer = 0; m_serv = 0; m_vec = '0;
      m_pend = '0; m_mask = '1; m_prev = '0;
    end else begin
      win = -1;
      for (int i = 0; i < N; i++)
        if (win < 0 && m_pend[i] && !m_mask[i]) win = i;
      np = m_pend;
      if (m_offer && win < 0) begin
        m_offer = 0;
      end else if (m_offer && int_ack) begin
        np[win] = 1'b0;
        m_vec   = 3'(win);
        m_serv  = 1;
        m_offer = 0;
      end else if (m_serv && int_eoi) begin
        m_serv = 0;
      end else if (!m_offer && !m_serv && win >= 0) begin
        m_offer = 1;
      end
      m_pend = np | (irq & ~m_prev);
      m_prev = irq;
      if (mask_we) m_mask = mask_wdata;
    end
    #1;
    chk("model_int",        {31'd0, intr},       {31'd0, m_offer});
    chk("model_int_vec",    {29'd0, int_vec},    {29'd0, m_vec});
    chk("model_pending",    {24'd0, pending},    {24'd0, m_pend});
    chk("model_in_service", {31'd0, in_service}, {31'd0, m_serv});
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic ack();
    int_ack = 1'b1; step(); int_ack = 1'b0;
  endtask

  task automatic eoi();
    int_eoi = 1'b1; step(); int_eoi = 1'b0;
  endtask

  task automatic wmask(input logic [N-1:0] m);
    mask_we = 1'b1; mask_wdata = m; step(); mask_we = 1'b0; mask_wdata = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with irq activity during reset
    rst = 1'b1; step(); irq = 8'hFF; step(); irq = 8'h00; step();
    rst = 1'b0; step();
    chk("rst_int", {31'd0, intr}, 32'd0);
    chk("rst_pending", {24'd0, pending}, 32'h00);
    step();
    chk("rst_masked_idle", {31'd0, intr}, 32'd0);
    wmask(8'h00);
    irq = 8'h20; step(); irq = 8'h00;
    chk("irq5_pending", {24'd0, pending}, 32'h20);
    chk("irq5_int_early", {31'd0, intr}, 32'd0);
    step();
    chk("irq5_int", {31'd0, intr}, 32'd1);
    ack();
    chk("irq5_vec", {29'd0, int_vec}, 32'd5);
    chk("irq5_insvc", {31'd0, in_service}, 32'd1);
    chk("irq5_int_drop", {31'd0, intr}, 32'd0);
    eoi();
    chk("irq5_eoi", {31'd0, in_service}, 32'd0);
    step();

    // Priority: lines 6 and 2 together
    irq = 8'h44; step(); irq = 8'h00; step();
    chk("prio_int", {31'd0, intr}, 32'd1);
    ack();
    chk("prio_vec2", {29'd0, int_vec}, 32'd2);
    chk("prio_pend", {24'd0, pending}, 32'h40);
    eoi();
    chk("prio_gap", {31'd0, intr}, 32'd0);
    step();
    chk("prio_reassert", {31'd0, intr}, 32'd1);
    ack();
    chk("prio_vec6", {29'd0, int_vec}, 32'd6);
    eoi(); step();

    // Masking holds pending, unmask releases it
    wmask(8'h08);
    irq = 8'h08; step(); irq = 8'h00; step(); step();
    chk("mask_pend", {24'd0, pending}, 32'h08);
    chk("mask_int0", {31'd0, intr}, 32'd0);
    wmask(8'h00);
    chk("unmask_int_early", {31'd0, intr}, 32'd0);
    step();
    chk("unmask_int", {31'd0, intr}, 32'd1);
    ack();
    chk("mask_vec3", {29'd0, int_vec}, 32'd3);
    eoi(); step();

    // Masking the only candidate while requesting withdraws int
    irq = 8'h04; step(); irq = 8'h00; step();
    chk("withdraw_int1", {31'd0, intr}, 32'd1);
    wmask(8'h04); step();
    chk("withdraw_int0", {31'd0, intr}, 32'd0);
    chk("withdraw_pend", {24'd0, pending}, 32'h04);
    wmask(8'h00); step();
    ack();
    chk("withdraw_vec2", {29'd0, int_vec}, 32'd2);
    eoi(); step();

    // Level held high yields a single request
    irq = 8'h02;
    repeat (20) step();
    irq = 8'h00;
    chk("level_pend", {24'd0, pending}, 32'h02);
    ack();
    chk("level_vec", {29'd0, int_vec}, 32'd1);
    eoi(); step();
    chk("level_once_pend", {24'd0, pending}, 32'h00);
    chk("level_once_int", {31'd0, intr}, 32'd0);

    // New edge on line 4 in the same cycle its ack lands
    irq = 8'h10; step(); irq = 8'h00; step();
    chk("coll_int", {31'd0, intr}, 32'd1);
    irq = 8'h10; int_ack = 1'b1; step(); irq = 8'h00; int_ack = 1'b0;
    chk("coll_vec", {29'd0, int_vec}, 32'd4);
    chk("coll_pend", {24'd0, pending}, 32'h10);
    eoi(); step();
    chk("coll_reassert", {31'd0, intr}, 32'd1);
    ack(); eoi(); step();

    // Handshake misuse
    ack();
    chk("idle_ack_insvc", {31'd0, in_service}, 32'd0);
    chk("idle_ack_int", {31'd0, intr}, 32'd0);
    chk("idle_ack_vec", {29'd0, int_vec}, 32'd4);
    irq = 8'h80; step(); irq = 8'h00; step();
    eoi();
    chk("req_eoi_int", {31'd0, intr}, 32'd1);
    ack();
    chk("serv_vec7", {29'd0, int_vec}, 32'd7);
    rst = 1'b1; step(); rst = 1'b0;
    chk("serv_rst_insvc", {31'd0, in_service}, 32'd0);
    chk("serv_rst_vec", {29'd0, int_vec}, 32'd0);

    // Mask returns to all-ones after reset
    irq = 8'h01; step(); irq = 8'h00; step(); step();
    chk("post_rst_pend", {24'd0, pending}, 32'h01);
    chk("post_rst_masked", {31'd0, intr}, 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
